mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word memory behind a valid/ready request channel and a
//   valid/ready response channel. One access is in flight at a time: a request
//   is accepted in IDLE, optionally waits WAIT_CYC cycles, then the access is
//   performed on the edge entering RESP and the response is held until the
//   initiator consumes it.
//
// Parameters
//   ADDR_W    word-index width; storage is 2**ADDR_W words of 32 bits
//   WAIT_CYC  wait states between acceptance and response (0 allowed)
//
// Ports
//   clk1       in   single clock, rising edge
//   rst_n      in   synchronous active-low reset (does not clear mem)
//   req_valid  in   request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   word address, low ADDR_W bits index mem
//   req_wdata  in   store data
//   req_ready  out  high in IDLE only
//   rsp_valid  out  high in RESP only
//   rsp_ready  in   response consumed
//   rsp_rdata  out  load data, 0 for stores
//   rsp_err    out  address error flag
//
// Build option
//   MEM_BOUNDS_CHECK_EN  when defined, a nonzero req_addr[31:ADDR_W] flags
//                        rsp_err, returns 0 and suppresses the store. When
//                        undefined, upper address bits are ignored (wrap) and
//                        rsp_err is always 0.
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic        clk1,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   // Counter only ever holds values up to WAIT_CYC-1.
   localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                oob_q, oob_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [31:0]         mem [0:DEPTH-1];

   // Access fields used on the RESP-entry edge: straight from the inputs when
   // entering RESP directly from IDLE (WAIT_CYC == 0), else the latched copy.
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_idx;
   logic [31:0]         acc_wdata;
   logic                acc_oob;
   logic                enter_resp;
   logic                mem_we;
   logic                req_oob;

`ifdef MEM_BOUNDS_CHECK_EN
   assign req_oob = |req_addr[31:ADDR_W];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W];
   assign req_oob        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      oob_d      = oob_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      acc_we     = we_q;
      acc_idx    = idx_q;
      acc_wdata  = wdata_q;
      acc_oob    = oob_q;

      case (state_q)
         IDLE: begin
            acc_we    = req_we;
            acc_idx   = req_addr[ADDR_W-1:0];
            acc_wdata = req_wdata;
            acc_oob   = req_oob;
            if (req_valid) begin
               we_d    = req_we;
               idx_d   = req_addr[ADDR_W-1:0];
               wdata_d = req_wdata;
               oob_d   = req_oob;
               if (WAIT_CYC == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYC - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      mem_we = enter_resp && acc_we && !acc_oob;
      if (enter_resp) begin
         err_d   = acc_oob;
         rdata_d = (acc_we || acc_oob) ? '0 : mem[acc_idx];
      end
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         oob_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         oob_q   <= oob_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage has no reset; a reset on the commit edge aborts the store.
   always_ff @(posedge clk1) begin
      if (rst_n && mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Scoreboard bench for mem_responder. Stimulus pushes the expected response
//   of each request into a queue; monitors pop and compare on every response
//   handshake and check response latency. u_dut runs WAIT_CYC=2, u_dut0 runs
//   WAIT_CYC=0 for the back-to-back case.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic        req_valid0, req_we0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   exp_t        q[$];
   exp_t        q0[$];

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) u_dut (
      .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err)
   );

   mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
      .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
      .rsp_err(rsp_err0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got timeout/unexpected expected handshake", name);
   endtask

   // Latency counted inclusively: the acceptance edge is edge 1, so a
   // response visible right after that edge has latency 1 (WAIT_CYC+1 overall).
   bit          pend = 0, prev_v = 0;
   int unsigned acc_cyc;
   exp_t        e;
   always @(negedge clk1) begin
      if (!rst_n) begin
         pend   = 0;
         prev_v = 0;
      end else begin
         if (req_valid && req_ready) begin
            acc_cyc = cyc + 1;
            pend    = 1;
         end
         if (rsp_valid && !prev_v) begin
            if (pend) chk("latency", cyc - acc_cyc + 1, 32'd3);
            else fail_now("rsp_without_accept");
            pend = 0;
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) fail_now("unexpected_rsp");
            else begin
               e = q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rd);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
         end
         prev_v = rsp_valid;
      end
   end

   bit          pend0 = 0, prev_v0 = 0, have_acc0 = 0;
   int unsigned acc_cyc0;
   exp_t        e0;
   always @(negedge clk1) begin
      if (!rst_n) begin
         pend0     = 0;
         prev_v0   = 0;
         have_acc0 = 0;
      end else begin
         if (req_valid0 && req_ready0) begin
            if (have_acc0) chk("accept_spacing0", cyc + 1 - acc_cyc0, 32'd2);
            acc_cyc0  = cyc + 1;
            pend0     = 1;
            have_acc0 = 1;
         end
         if (rsp_valid0 && !prev_v0) begin
            if (pend0) chk("latency0", cyc - acc_cyc0 + 1, 32'd1);
            else fail_now("rsp_without_accept0");
            pend0 = 0;
         end
         if (rsp_valid0 && rsp_ready0) begin
            if (q0.size() == 0) fail_now("unexpected_rsp0");
            else begin
               e0 = q0.pop_front();
               chk("rsp_rdata0", rsp_rdata0, e0.rd);
               chk("rsp_err0", {31'b0, rsp_err0}, {31'b0, e0.err});
            end
         end
         prev_v0 = rsp_valid0;
      end
   end

   // Presents a request, waits for acceptance, then scrambles the req_* inputs
   // so that any later use of live inputs by the DUT shows up as bad data.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit exp_rsp, input logic [31:0] erd, input logic eerr);
      bit ok = 0;
      if (exp_rsp) q.push_back('{rd: erd, err: eerr});
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk1);
         if (req_ready) ok = 1;
      end
      if (!ok) begin
         fail_now("accept_timeout");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk1);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = ~addr;
      req_wdata = ~wd;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk1);
         if (rsp_valid && rsp_ready) ok = 1;
      end
      if (!ok) begin
         fail_now("response_timeout");
         return;
      end
      @(posedge clk1);
      #1;
   endtask

   logic        b2b_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] b2b_ad [4] = '{32'd5, 32'd5, 32'd6, 32'd6};
   logic [31:0] b2b_wd [4] = '{32'd11, 32'd0, 32'd22, 32'd0};
   logic [31:0] b2b_rd [4] = '{32'd0, 32'd11, 32'd0, 32'd22};

   initial begin
      bit ok;
      rst_n     = 1'b0;
      req_valid = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; rsp_ready  = 1'b1;
      req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
      u_dut.mem[120] = 32'd85;
      u_dut.mem[200] = 32'd55;

      repeat (2) @(posedge clk1);
      @(negedge clk1);
      chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
      @(posedge clk1);
      #1 rst_n = 1'b1;

      // Preloaded load
      issue(1'b0, 32'd120, 32'd0, 1, 32'd85, 1'b0);
      wait_done();

      // Store then load back
      issue(1'b1, 32'd121, 32'd130, 1, 32'd0, 1'b0);
      wait_done();
      chk("mem121_after_store", u_dut.mem[121], 32'd130);
      issue(1'b0, 32'd121, 32'd0, 1, 32'd130, 1'b0);
      wait_done();

      // Backpressure: response must hold while rsp_ready is low
      rsp_ready = 1'b0;
      issue(1'b0, 32'd120, 32'd0, 1, 32'd85, 1'b0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk1);
         if (rsp_valid) ok = 1;
      end
      if (!ok) fail_now("stall_valid_timeout");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk1);
         chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("stall_rsp_rdata", rsp_rdata, 32'd85);
         chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk1);
      #1 rsp_ready = 1'b1;
      wait_done();
      chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("post_rsp_rdata", rsp_rdata, 32'd0);
      chk("post_req_ready", {31'b0, req_ready}, 32'd1);

      // Reset in the second WAIT cycle aborts the store
      issue(1'b1, 32'd200, 32'd7, 0, 32'd0, 1'b0);
      @(posedge clk1);
      #1 rst_n = 1'b0;
      @(posedge clk1);
      #1 rst_n = 1'b1;
      chk("abort_mem200", u_dut.mem[200], 32'd55);
      chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("abort_rsp_rdata", rsp_rdata, 32'd0);
      chk("abort_rsp_err", {31'b0, rsp_err}, 32'd0);
      issue(1'b0, 32'd200, 32'd0, 1, 32'd55, 1'b0);
      wait_done();

      // Upper address bits: 0x478 indexes word 120
`ifdef MEM_BOUNDS_CHECK_EN
      issue(1'b0, 32'h0000_0478, 32'd0, 1, 32'd0, 1'b1);
`else
      issue(1'b0, 32'h0000_0478, 32'd0, 1, 32'd85, 1'b0);
`endif
      wait_done();

      // Top index
      issue(1'b1, 32'd1023, 32'hDEAD_BEEF, 1, 32'd0, 1'b0);
      wait_done();
      issue(1'b0, 32'd1023, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
      wait_done();

      // WAIT_CYC=0 instance, req_valid held high across requests
      req_valid0 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         q0.push_back('{rd: b2b_rd[k], err: 1'b0});
         req_we0    = b2b_we[k];
         req_addr0  = b2b_ad[k];
         req_wdata0 = b2b_wd[k];
         ok = 0;
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk1);
            if (req_ready0) ok = 1;
         end
         if (!ok) fail_now("accept_timeout0");
         @(posedge clk1);
         #1;
      end
      req_valid0 = 1'b0;
      for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk1);
      @(negedge clk1);

      chk("scoreboard_empty", q.size(), 32'd0);
      chk("scoreboard0_empty", q0.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
